// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing unit: program counter, one-stage instruction
// register with single-bubble branch flush, Start/Done handshake and retired count.
module fetch_unit #(
    parameter int                 PC_W    = 10,
    parameter int                 INSTR_W = 9,
    parameter logic [INSTR_W-1:0] BUBBLE  = 9'h1E0,
    parameter int                 CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               BranchEn,
    input  logic               Taken,
    input  logic [PC_W-1:0]    Target,
    input  logic               Ack,
    output logic [PC_W-1:0]    ProgCtr,
    output logic [INSTR_W-1:0] Instruction,
    output logic [PC_W-1:0]    ExecPC,
    output logic               InstrValid,
    output logic               Done,
    output logic [CNT_W-1:0]   InstrCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_exec_pc;
    logic               r_valid;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic [PC_W-1:0]    w_exec_pc_nxt;
    logic               w_valid_nxt;
    logic               w_done_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Retired count saturates at all-ones rather than wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= BUBBLE;
            r_exec_pc <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_exec_pc <= w_exec_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_exec_pc_nxt = r_exec_pc;
        w_valid_nxt   = r_valid;
        w_done_nxt    = r_done;
        w_cnt_nxt     = r_cnt;

        if (Start) begin
            w_state_nxt = S_HOLD;
            w_pc_nxt    = '0;
            w_ir_nxt    = BUBBLE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_state_nxt   = S_RUN;
                    w_ir_nxt      = InstrIn;
                    w_exec_pc_nxt = r_pc;
                    w_pc_nxt      = r_pc + 1'b1;
                    w_valid_nxt   = 1'b1;
                end
                S_RUN: begin
                    // Halt takes precedence over a branch flagged on the same word.
                    if (r_valid && Ack) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_ir_nxt    = BUBBLE;
                        w_valid_nxt = 1'b0;
                    end else if (r_valid && BranchEn && Taken) begin
                        w_pc_nxt    = Target;
                        w_ir_nxt    = BUBBLE;
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = w_cnt_inc;
                    end else begin
                        w_ir_nxt      = InstrIn;
                        w_exec_pc_nxt = r_pc;
                        w_pc_nxt      = r_pc + 1'b1;
                        w_valid_nxt   = 1'b1;
                        if (r_valid) begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ProgCtr     = r_pc;
    assign Instruction = r_ir;
    assign ExecPC      = r_exec_pc;
    assign InstrValid  = r_valid;
    assign Done        = r_done;
    assign InstrCount  = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM and decoder stand-in,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_unit;

    localparam int         PC_W    = 10;
    localparam int         INSTR_W = 9;
    localparam int         CNT_W   = 16;
    localparam logic [8:0] BUBBLE  = 9'h1E0;
    localparam logic [8:0] HALT    = 9'h1FF;
    localparam logic [8:0] ALU_OP  = 9'h003;
    localparam logic [8:0] BR_OP   = 9'h1C0;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Start;
    logic [INSTR_W-1:0] InstrIn;
    logic               BranchEn;
    logic               Taken;
    logic [PC_W-1:0]    Target;
    logic               Ack;
    logic [PC_W-1:0]    ProgCtr;
    logic [INSTR_W-1:0] Instruction;
    logic [PC_W-1:0]    ExecPC;
    logic               InstrValid;
    logic               Done;
    logic [CNT_W-1:0]   InstrCount;

    logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];
    logic               br_force;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    always #5 Clk = ~Clk;

    // Combinational ROM and a minimal decoder: opcode 1110 is a branch, 9'h1FF halts.
    assign InstrIn  = rom[ProgCtr];
    assign BranchEn = (Instruction[8:5] == 4'b1110) || br_force;
    assign Ack      = (Instruction == HALT);

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .InstrIn     (InstrIn),
        .BranchEn    (BranchEn),
        .Taken       (Taken),
        .Target      (Target),
        .Ack         (Ack),
        .ProgCtr     (ProgCtr),
        .Instruction (Instruction),
        .ExecPC      (ExecPC),
        .InstrValid  (InstrValid),
        .Done        (Done),
        .InstrCount  (InstrCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Taken    = 1'b0;
        Target   = '0;
        br_force = 1'b0;
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = ALU_OP;
        rom[4] = HALT;

        // Reset values
        #12;
        check("rst_pc", ProgCtr, 0);
        check("rst_ir", Instruction, BUBBLE);
        check("rst_exec", ExecPC, 0);
        check("rst_valid", InstrValid, 0);
        check("rst_done", Done, 0);
        check("rst_cnt", InstrCount, 0);
        Reset = 1'b0;
        step();
        step();
        check("idle_pc", ProgCtr, 0);
        check("idle_valid", InstrValid, 0);

        // Linear program ending in halt; halt word also flagged as taken branch
        Start = 1'b1;
        step();
        check("A_hold_pc", ProgCtr, 0);
        check("A_hold_valid", InstrValid, 0);
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("A_exec", ExecPC, i);
            check("A_ir", Instruction, rom[i]);
            check("A_valid", InstrValid, 1);
        end
        check("A_cnt", InstrCount, 4);
        br_force = 1'b1;
        Taken    = 1'b1;
        Target   = 10'd10;
        step();
        check("A_done", Done, 1);
        check("A_done_pc", ProgCtr, 5);
        check("A_done_valid", InstrValid, 0);
        check("A_done_ir", Instruction, BUBBLE);
        check("A_done_cnt", InstrCount, 4);
        br_force = 1'b0;
        Taken    = 1'b0;
        step();
        check("A_hold_done", Done, 1);
        check("A_hold_pc2", ProgCtr, 5);

        // Taken branch at address 2 to 10
        rom[4] = ALU_OP;
        rom[2] = BR_OP;
        Taken  = 1'b1;
        Target = 10'd10;
        Start  = 1'b1;
        step();
        check("B_clr_done", Done, 0);
        check("B_clr_cnt", InstrCount, 0);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("B_exec", ExecPC, i);
        end
        step();
        check("B_bub_valid", InstrValid, 0);
        check("B_bub_pc", ProgCtr, 10);
        check("B_bub_ir", Instruction, BUBBLE);
        check("B_bub_cnt", InstrCount, 3);
        step();
        check("B_tgt_exec", ExecPC, 10);
        check("B_tgt_pc", ProgCtr, 11);
        check("B_tgt_valid", InstrValid, 1);
        check("B_tgt_cnt", InstrCount, 3);
        step();
        check("B_tgt1_exec", ExecPC, 11);
        check("B_tgt1_cnt", InstrCount, 4);

        // Same branch not taken
        Taken = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("C_br_exec", ExecPC, 2);
        step();
        check("C_exec", ExecPC, 3);
        check("C_valid", InstrValid, 1);
        check("C_cnt", InstrCount, 3);
        check("C_pc", ProgCtr, 4);

        // Start pulse of 3 cycles mid-run
        rom[2] = ALU_OP;
        Start  = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 21; i++) step();
        check("D_exec20", ExecPC, 20);
        check("D_cnt20", InstrCount, 20);
        Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("D_hold_pc", ProgCtr, 0);
            check("D_hold_valid", InstrValid, 0);
            check("D_hold_cnt", InstrCount, 0);
        end
        Start = 1'b0;
        step();
        check("D_re_exec", ExecPC, 0);
        check("D_re_cnt", InstrCount, 0);
        check("D_re_valid", InstrValid, 1);
        step();
        check("D_re_exec1", ExecPC, 1);
        check("D_re_cnt1", InstrCount, 1);

        // PC wrap 1023 -> 0
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 1024; i++) step();
        check("E_exec1023", ExecPC, 1023);
        check("E_pc_wrap", ProgCtr, 0);
        check("E_cnt", InstrCount, 1023);
        step();
        check("E_exec0", ExecPC, 0);
        check("E_pc1", ProgCtr, 1);
        check("E_cnt2", InstrCount, 1024);

        // Asynchronous reset mid-run at ProgCtr=37
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 37; i++) step();
        check("F_pre_pc", ProgCtr, 37);
        #2;
        Reset = 1'b1;
        #1;
        check("F_pc", ProgCtr, 0);
        check("F_ir", Instruction, BUBBLE);
        check("F_valid", InstrValid, 0);
        check("F_done", Done, 0);
        check("F_cnt", InstrCount, 0);
        step();
        Reset = 1'b0;
        step();
        check("F_idle_valid", InstrValid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch/sequencing unit: the PC-side consumer of the control decoder's BranchEn/Ack outputs, and the producer of the 9-bit Instruction word the decoder consumes.
- Holds the program counter and drives the instruction ROM address; ROM read is combinational.
- Registers the fetched word in a one-stage instruction register (IR) feeding the decoder.
- Handles taken branches with a one-bubble flush, the Start/Done program handshake, and a retired-instruction counter.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, instruction width
BUBBLE, 9'h1E0, injected no-op word (opcode 1111, operand 0; decodes to no enables and is not Ack)
CNT_W, 16, retired-instruction counter width

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  level; high = hold program at address 0, falling edge begins execution
InstrIn  input  INSTR_W  instruction ROM data for address ProgCtr (same cycle)
BranchEn  input  1  from decoder: current IR word is a branch
Taken  input  1  branch condition from ALU flags, valid with BranchEn
Target  input  PC_W  absolute branch target (from branch LUT)
Ack  input  1  from decoder: current IR word is the halt word
ProgCtr  output  PC_W  ROM fetch address
Instruction  output  INSTR_W  IR contents, to decoder
ExecPC  output  PC_W  address of the word currently in IR
InstrValid  output  1  IR holds a real instruction; downstream write enables are gated by it
Done  output  1  program halted
InstrCount  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset (async, any state): state=IDLE, ProgCtr=0, Instruction=BUBBLE, ExecPC=0, InstrValid=0, Done=0, InstrCount=0.
- States: IDLE, HOLD, RUN, DONE.
- Priority each cycle: Start > Ack > taken branch > sequential fetch.
- Start=1 in any state → next state HOLD: ProgCtr<=0, Instruction<=BUBBLE, InstrValid<=0, Done<=0, InstrCount<=0. The unit stays in HOLD while Start remains high.
- HOLD with Start=0 → RUN: Instruction<=InstrIn (ROM[0]), ExecPC<=0, ProgCtr<=1, InstrValid<=1.
- IDLE: all outputs held until Start is high.
- RUN, InstrValid=1 and Ack=1 → DONE:
  - Done<=1, Instruction<=BUBBLE, InstrValid<=0, ProgCtr holds.
  - The halt word is not counted.
- RUN, InstrValid=1, BranchEn=1, Taken=1 (flush):
  - ProgCtr<=Target, Instruction<=BUBBLE, InstrValid<=0.
  - Next cycle: Instruction<=ROM[Target], ExecPC<=Target, ProgCtr<=Target+1, InstrValid<=1.
  - Branch penalty is exactly 1 bubble. The branch itself counts as retired.
- RUN, BranchEn=1 with Taken=0: the branch counts as retired and fetch continues sequentially.
- RUN otherwise (sequential fetch):
  - Instruction<=InstrIn, ExecPC<=ProgCtr, ProgCtr<=ProgCtr+1, InstrValid<=1.
  - InstrCount increments if the outgoing IR word was valid.
- BranchEn/Ack with InstrValid=0 (bubble) are ignored.
- ProgCtr+1 wraps modulo 2^PC_W (1023→0). Target is used unmodified.
- InstrCount saturates at 2^CNT_W-1.
- DONE: all outputs held, Done=1 until Start or Reset.
- Ack and BranchEn asserted together: Ack wins and the branch is not taken.

Test Plan:
- Reset mid-RUN at ProgCtr=37 → same cycle, asynchronously: ProgCtr=0, Instruction=9'h1E0, InstrValid=0, Done=0, InstrCount=0.
- ROM[0..3]=ALU ops, ROM[4]=9'h1FF; Start 1→0 → ExecPC 0,1,2,3,4 on consecutive cycles; Done=1 the cycle after ExecPC=4; InstrCount=4.
- ROM[2] is a branch with Taken=1, Target=10 → cycle after ExecPC=2: InstrValid=0, ProgCtr=10; next cycle ExecPC=10, ProgCtr=11.
- Same branch with Taken=0 → ExecPC=3 follows with no bubble; InstrCount includes the branch.
- Linear program running to ProgCtr=1023 → next fetch address 0, ExecPC=1023 then 0.
- Start pulsed high for 3 cycles during RUN at ExecPC=20 → HOLD for 3 cycles with ProgCtr=0; after Start falls, ExecPC=0 and InstrCount restarts from 0.
